sap_core: RTL and testbench
===========================

# sap_core

Parametrised successor to the SAP-1 CPU top: a multi-cycle accumulator processor with configurable data and address width, carry/zero flags, store and conditional-jump instructions, and handshaked memory and output ports. The core replaces the fixed-latency internal RAM and free-running T-state counter with a single control FSM. That FSM tolerates variable-latency memory and a back-pressured output consumer. It sits between a unified instruction/data memory and an output sink, and is the drop-in core for system-level benches.

## Interface
Parameters:
- DATA_W, 8, accumulator/memory word width; instruction = opcode in bits [DATA_W-1:DATA_W-4], operand in [DATA_W-5:0]; must be ≥ 8
- ADDR_W, 4, address width; must satisfy ADDR_W ≤ DATA_W-4; PC and memory address are ADDR_W bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request; held with stable mem_addr/mem_we/mem_wdata until acknowledged
- mem_we  out  1  1 = write (STA), 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data (= A)
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  completes the request in the cycle it is seen with mem_req=1
- out_valid  out  1  out_data holds a value for the sink
- out_data  out  DATA_W  output register contents
- out_ready  in  1  sink accepts when out_valid & out_ready
- halted  out  1  core is in HALT
- pc  out  ADDR_W  current program counter (debug)

## Operation
- Opcodes:
  - 0 LDA: A←M[op].
  - 1 ADD: A←A+M[op].
  - 2 SUB: A←A−M[op].
  - 3 STA: M[op]←A.
  - 4 LDI: A←zero-extended op.
  - 5 JMP: PC←op.
  - 6 JC: jump if C.
  - 7 JZ: jump if Z.
  - 14 OUT: out_data←A, then handshake.
  - 15 HLT.
  - 8–13: NOP.
- Memory addresses and jump targets use operand bits [ADDR_W-1:0]; higher operand bits are ignored. LDI uses the full DATA_W-4-bit operand.
- Flags:
  - ADD: C = carry out.
  - SUB: C = no-borrow, i.e. A ≥ M unsigned.
  - Z = (new A == 0), updated by LDA/ADD/SUB/LDI.
  - LDA and LDI leave C unchanged. All other instructions leave both flags unchanged.
- FSM states: FETCH, DECODE, MEM, OUT, HALT.
  - FETCH: mem_req=1, mem_we=0, addr=PC. On ack: IR←rdata, PC←PC+1 (wraps 2^ADDR_W−1→0), go to DECODE.
  - DECODE, one cycle:
    - LDA/ADD/SUB/STA → MEM.
    - LDI: update A and Z → FETCH.
    - JMP/JC/JZ: load PC if taken → FETCH.
    - OUT: out_data←A, out_valid←1 → OUT.
    - HLT → HALT.
    - NOP → FETCH.
  - MEM: mem_req=1, addr=operand, we=(STA). On ack: perform the ALU/load or complete the store, then FETCH.
  - OUT: wait for out_ready; on accept, out_valid←0 → FETCH. out_data keeps its value after acceptance.
  - HALT: absorbing; mem_req=0, halted=1. Exit only by reset.
- mem_ack with mem_req=0 is ignored. out_ready with out_valid=0 is ignored.

## Timing
- Reset (async assert, synchronous release behaviour on next edge):
  - State=FETCH; PC, A, IR, C, Z, out_data = 0.
  - mem_req, out_valid, halted = 0. mem_req drops combinationally on rst_n low.
  - The first mem_req is asserted in the first cycle after rst_n deasserts.
- Cycles with zero-wait memory (ack in the same cycle as req):
  - 3 cycles: LDA/ADD/SUB/STA.
  - 2 cycles: LDI/JMP/JC/JZ/NOP.
  - 2 + stall cycles: OUT, where stall = cycles out_valid waits for out_ready. Accept in the first OUT cycle gives 3 cycles total.
- Each wait cycle on mem_ack adds one cycle. Request outputs are stable throughout the wait.
- Flags and A are visible to the next instruction's DECODE, with no hazard.
- Reset mid-request or mid-OUT aborts immediately. No write completes unless the ack edge preceded reset.

## Structure
- Package sap_pkg: opcode localparams/enum (LDA…HLT), FSM state enum, and flag indices.
- One sub-module, sap_alu: combinational DATA_W add/sub producing result, carry/no-borrow and zero. Instantiated once by sap_core.
- Registers (PC, A, IR, flags, out_data) and the FSM live in sap_core.

## Test plan
- Zero-wait memory, program LDA 9; ADD 10; OUT; HLT with M[9]=0x1C, M[10]=0x0E: out_data=0x2A, out_valid for one cycle with out_ready=1, halted=1; 12 cycles from reset release to halted.
- SUB borrow/zero: A=5, SUB M=5 → A=0, Z=1, C=1. Then SUB M=1 → A=0xFF, Z=0, C=0. JC not taken, JZ not taken.
- Loop with STA/JZ: decrement a counter in RAM from 3 to 0. Expect exactly 3 OUT transactions (2, 1, 0), then HLT; RAM word equals 0.
- Random 0–4-cycle mem_ack delay plus out_ready held low for 5 cycles: identical results to the zero-wait case; mem_addr/mem_we stable while waiting; out_valid held for 6 cycles.
- PC wrap with ADDR_W=4: NOP at address 15 → next fetch address 0. With DATA_W=12, ADDR_W=6: LDI 0xFF loads 0x0FF, and JMP uses operand[5:0].
- Assert rst_n low during a MEM wait for STA: mem_req falls immediately and memory is unchanged. After release, fetch restarts at address 0 with A=0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the sap_core accumulator processor: opcodes,
// control FSM states and flag register layout.
package sap_pkg;

  // Opcode field values; 8..13 are unassigned and execute as NOP.
  typedef enum logic [3:0] {
    OP_LDA = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_STA = 4'd3,
    OP_LDI = 4'd4,
    OP_JMP = 4'd5,
    OP_JC  = 4'd6,
    OP_JZ  = 4'd7,
    OP_OUT = 4'd14,
    OP_HLT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_OUT,
    S_HALT
  } state_e;

  // Bit positions inside the flag register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_W = 2;

  // Instructions that need a second memory transaction.
  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit. For SUB the carry output is the
// no-borrow flag (a >= b unsigned), which falls out of a + ~b + 1.
module sap_alu
  import sap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic              sub;
  logic [DATA_W:0]   sum;

  // Single adder shared by ADD and SUB; SUB inverts b and injects a carry-in.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a value on every path, so no latch can be inferred.
    sub    = (op == OP_SUB);
    sum    = {1'b0, a} + {1'b0, b ^ {DATA_W{sub}}} + {{DATA_W{1'b0}}, sub};
    result = sum[DATA_W-1:0];
    carry  = sum[DATA_W];
    zero   = (sum[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/sap_core.sv
// Multi-cycle accumulator core with a unified handshaked memory port and a
// back-pressured output port. A single FSM sequences fetch, decode, an
// optional memory access, the output handshake and halt.
module sap_core
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  state_e              state;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   ir;
  logic [FLAG_W-1:0]   flags;

  opcode_e             opcode;
  logic [DATA_W-5:0]   operand;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W-1:0]   ldi_value;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic                alu_zero;

  assign opcode    = opcode_e'(ir[DATA_W-1 -: 4]);
  assign operand   = ir[DATA_W-5:0];
  assign target    = operand[ADDR_W-1:0];
  assign ldi_value = {4'b0000, operand};

  // NOTE: the request is gated by rst_n so it drops the moment reset asserts,
  // not at the next edge; everything else is a decode of registered state,
  // which keeps address/we/wdata stable for as long as the ack is pending.
  assign mem_req   = rst_n && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && (opcode == OP_STA);
  assign mem_addr  = (state == S_MEM) ? target : pc;
  assign mem_wdata = a;

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a),
    .b      (mem_rdata),
    .op     (opcode),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Control FSM together with the architectural registers it updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      a         <= '0;
      ir        <= '0;
      flags     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + 1'b1;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          state <= S_FETCH;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state <= S_MEM;
            OP_LDI: begin
              a             <= ldi_value;
              flags[FLAG_Z] <= (ldi_value == '0);
            end
            OP_JMP: pc <= target;
            OP_JC:  if (flags[FLAG_C]) pc <= target;
            OP_JZ:  if (flags[FLAG_Z]) pc <= target;
            OP_OUT: begin
              out_data  <= a;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end

        S_MEM: begin
          if (mem_ack) begin
            case (opcode)
              OP_LDA: begin
                a             <= mem_rdata;
                flags[FLAG_Z] <= (mem_rdata == '0);
              end
              OP_ADD, OP_SUB: begin
                a             <= alu_result;
                flags[FLAG_C] <= alu_carry;
                flags[FLAG_Z] <= alu_zero;
              end
              default: ;
            endcase
            state <= S_FETCH;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

  // Only memory-class opcodes may reach S_MEM.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_MEM) begin
      assert (is_mem_op(opcode));
    end
  end

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: directed programs from the test plan,
// randomized forward-only programs, random memory latency and output
// back-pressure, all compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_sap_core;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int MSZ  = 16;
  localparam int WDW  = 12;
  localparam int WAW  = 6;
  localparam int WMSZ = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Narrow core (DATA_W=8, ADDR_W=4)
  logic          mem_req, mem_we, mem_ack, out_valid, out_ready, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, out_data;

  sap_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .halted(halted), .pc(pc)
  );

  // Wide core (DATA_W=12, ADDR_W=6)
  logic           w_mem_req, w_mem_we, w_mem_ack, w_out_valid, w_out_ready, w_halted;
  logic [WAW-1:0] w_mem_addr, w_pc;
  logic [WDW-1:0] w_mem_wdata, w_mem_rdata, w_out_data;

  sap_core #(.DATA_W(WDW), .ADDR_W(WAW)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata), .mem_ack(w_mem_ack),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(w_out_ready),
    .halted(w_halted), .pc(w_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- narrow memory and sink ----------------
  logic [DW-1:0] mem  [MSZ];
  logic [DW-1:0] prog [MSZ];
  int            delay_mode = 0;  // 0 zero-wait, 1 random 0..4, 3 writes never acked
  int            stall = 0;       // cycles out_ready stays low per output
  bit            pending = 0;
  int            wait_left = 0;
  logic [AW-1:0] held_addr;
  logic          held_we;
  logic [DW-1:0] held_wdata;
  int            stab_err = 0;
  bit            commit_pending = 0;
  logic [AW-1:0] commit_addr;
  logic [DW-1:0] commit_data;
  int            req_log[$];
  int            outs[$];
  int            valid_cycles = 0;
  int            last_run = 0;

  always @(negedge clk) begin
    if (commit_pending && rst_n) mem[commit_addr] = commit_data;
    commit_pending = 0;
    if (mem_req) begin
      if (!pending) begin
        pending    = 1;
        held_addr  = mem_addr;
        held_we    = mem_we;
        held_wdata = mem_wdata;
        wait_left  = (delay_mode == 1) ? int'($urandom_range(0, 4)) :
                     ((delay_mode == 3 && mem_we) ? 1000 : 0);
      end else if (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wdata) begin
        stab_err++;
      end
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        req_log.push_back(int'(mem_addr));
        if (mem_we) begin
          commit_pending = 1;
          commit_addr    = mem_addr;
          commit_data    = mem_wdata;
        end
        pending = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        wait_left--;
      end
    end else begin
      pending   = 0;
      mem_ack   = (delay_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = DW'($urandom);
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cycles++;
      if (valid_cycles > stall) begin
        out_ready = 1'b1;
        outs.push_back(int'(out_data));
        last_run     = valid_cycles;
        valid_cycles = 0;
      end else begin
        out_ready = 1'b0;
      end
    end else begin
      valid_cycles = 0;
      out_ready    = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- wide memory and sink ----------------
  logic [WDW-1:0] w_mem [WMSZ];
  int             w_outs[$];

  always @(negedge clk) begin
    w_mem_ack   = w_mem_req;
    w_mem_rdata = w_mem[w_mem_addr];
    if (w_mem_req && w_mem_we) w_mem[w_mem_addr] = w_mem_wdata;
    if (w_out_valid) w_outs.push_back(int'(w_out_data));
  end

  // ---------------- reference model ----------------
  int exp_mem [MSZ];
  int exp_outs[$];
  int exp_pc;
  int exp_cycles;

  // Instruction-level interpreter; cycle cost is per instruction class with
  // zero-wait memory and an immediately ready sink.
  task automatic model_run();
    int img [MSZ];
    int p = 0, acc = 0, cf = 0, zf = 0, ins, op, opd, ea;
    bit done = 0;
    for (int i = 0; i < MSZ; i++) img[i] = int'(prog[i]);
    exp_outs.delete();
    exp_cycles = 0;
    for (int step = 0; step < 1000 && !done; step++) begin
      ins = img[p];
      p   = (p + 1) % MSZ;
      op  = ins / 16;
      opd = ins % 16;
      ea  = opd % MSZ;
      case (op)
        0: begin acc = img[ea]; zf = int'(acc == 0); exp_cycles += 3; end
        1: begin acc = acc + img[ea]; cf = int'(acc > 255); acc = acc % 256;
                 zf = int'(acc == 0); exp_cycles += 3; end
        2: begin cf = int'(acc >= img[ea]); acc = (acc - img[ea] + 256) % 256;
                 zf = int'(acc == 0); exp_cycles += 3; end
        3: begin img[ea] = acc; exp_cycles += 3; end
        4: begin acc = opd; zf = int'(acc == 0); exp_cycles += 2; end
        5: begin p = ea; exp_cycles += 2; end
        6: begin if (cf != 0) p = ea; exp_cycles += 2; end
        7: begin if (zf != 0) p = ea; exp_cycles += 2; end
        14: begin exp_outs.push_back(acc); exp_cycles += 3; end
        15: begin done = 1; exp_cycles += 2; end
        default: exp_cycles += 2;
      endcase
    end
    for (int i = 0; i < MSZ; i++) exp_mem[i] = img[i];
    exp_pc = p;
  endtask

  // ---------------- run helpers ----------------
  task automatic clear_logs();
    outs.delete();
    req_log.delete();
    w_outs.delete();
    stab_err = 0;
    last_run = 0;
  endtask

  task automatic start_prog(input int dmode, input int st);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < MSZ; i++) mem[i] = prog[i];
    delay_mode = dmode;
    stall      = st;
    clear_logs();
    model_run();
    @(negedge clk);
    check("rst mem_req", 32'(mem_req), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst halted", 32'(halted), 0);
    check("rst pc", 32'(pc), 0);
    check("rst out_data", 32'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic finish_prog(input string name, input bit timed);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 4000);
    check($sformatf("%s halted", name), 32'(halted), 1);
    if (timed) check($sformatf("%s halt_cycle", name), n, exp_cycles + 1);
    check($sformatf("%s n_out", name), outs.size(), exp_outs.size());
    for (int i = 0; i < exp_outs.size() && i < outs.size(); i++)
      check($sformatf("%s out[%0d]", name, i), outs[i], exp_outs[i]);
    for (int i = 0; i < MSZ; i++)
      check($sformatf("%s mem[%0d]", name, i), 32'(mem[i]), exp_mem[i]);
    check($sformatf("%s pc", name), 32'(pc), exp_pc);
    check($sformatf("%s req_stable", name), stab_err, 0);
    repeat (3) @(negedge clk);
    check($sformatf("%s halt_no_req", name), 32'(mem_req), 0);
    check($sformatf("%s halt_no_valid", name), 32'(out_valid), 0);
    if (exp_outs.size() > 0)
      check($sformatf("%s out_data_kept", name), 32'(out_data), exp_outs[exp_outs.size()-1]);
  endtask

  task automatic set_prog(input logic [8*MSZ-1:0] words);
    for (int i = 0; i < MSZ; i++) prog[i] = words[8*(MSZ-1-i) +: 8];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, wrap_next, op_sel;
    bit found;
    rst_n     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    out_ready = 1'b0;
    w_out_ready = 1'b1;
    for (int i = 0; i < WMSZ; i++) w_mem[i] = 12'hF00;
    w_mem[0] = 12'h4FF;  // LDI 0xFF
    w_mem[1] = 12'hE00;  // OUT
    w_mem[2] = 12'h5C5;  // JMP 0xC5 -> address 5
    w_mem[5] = 12'h43C;  // LDI 0x3C
    w_mem[6] = 12'hE00;  // OUT
    w_mem[7] = 12'hF00;  // HLT
    #1 rst_n = 1'b0;

    // LDA 9; ADD 10; OUT; HLT
    set_prog(128'h091A_E0F0_0000_0000_001C_0E00_0000_0000);
    start_prog(0, 0);
    finish_prog("basic", 1);
    check("basic out", (outs.size() > 0) ? outs[0] : -1, 32'h2A);
    check("basic valid_run", last_run, 1);
    n = 0;
    while (!w_halted && n < 200) begin @(negedge clk); n++; end
    check("wide halted", 32'(w_halted), 1);
    check("wide n_out", w_outs.size(), 2);
    check("wide ldi", (w_outs.size() > 0) ? w_outs[0] : -1, 32'h0FF);
    check("wide jmp", (w_outs.size() > 1) ? w_outs[1] : -1, 32'h03C);
    check("wide pc", 32'(w_pc), 8);

    // Same program under random latency and 5 cycles of back-pressure
    start_prog(1, 5);
    finish_prog("basic_slow", 0);
    check("basic_slow out", (outs.size() > 0) ? outs[0] : -1, 32'h2A);
    check("basic_slow valid_run", last_run, 6);

    // SUB to zero (Z=1,C=1), then SUB 1 to 0xFF (Z=0,C=0), JC/JZ not taken
    set_prog(128'h452E_74F0_66F0_E02F_6C7C_E0F0_41F0_0501);
    start_prog(0, 0);
    finish_prog("sub", 1);
    check("sub zero", (outs.size() > 0) ? outs[0] : -1, 32'h00);
    check("sub borrow", (outs.size() > 1) ? outs[1] : -1, 32'hFF);

    // Counter in RAM decremented 3 -> 0 with STA/JZ
    set_prog(128'h0F2E_3FE0_7650_F000_0000_0000_0000_0103);
    for (int k = 0; k < 2; k++) begin
      start_prog(k, 2 * k);
      finish_prog($sformatf("loop%0d", k), k == 0);
      check($sformatf("loop%0d n_out", k), outs.size(), 3);
      for (int i = 0; i < 3 && i < outs.size(); i++)
        check($sformatf("loop%0d val%0d", k, i), outs[i], 2 - i);
      check($sformatf("loop%0d ram", k), 32'(mem[15]), 0);
    end

    // PC wrap: NOP at 15 is followed by a fetch from 0
    set_prog(128'h7540_E05F_F049_E0F0_F0F0_F0F0_F0F0_F080);
    start_prog(0, 0);
    finish_prog("wrap", 1);
    wrap_next = -1;
    for (int i = 0; i + 1 < req_log.size(); i++)
      if (req_log[i] == 15 && wrap_next < 0) wrap_next = req_log[i+1];
    check("wrap next_fetch", wrap_next, 0);

    // Random forward-only programs: code 0..10, HLT at 11, data 12..15
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 11; i++) begin
        op_sel = int'($urandom_range(0, 9));
        case (op_sel)
          0, 1, 2, 3: prog[i] = DW'(op_sel * 16 + 12 + int'($urandom_range(0, 3)));
          4:          prog[i] = DW'(16 * 4 + int'($urandom_range(0, 15)));
          5, 6, 7:    prog[i] = DW'(op_sel * 16 + int'($urandom_range(i + 1, 11)));
          8:          prog[i] = DW'(16 * 14 + int'($urandom_range(0, 15)));
          default:    prog[i] = DW'(16 * int'($urandom_range(8, 13)) + int'($urandom_range(0, 15)));
        endcase
      end
      prog[11] = 8'hF0;
      for (int i = 12; i < MSZ; i++) prog[i] = DW'($urandom);
      if (t % 3 == 0) start_prog(0, 0);
      else            start_prog(1, int'($urandom_range(0, 3)));
      finish_prog($sformatf("rand%0d", t), t % 3 == 0);
    end

    // Reset while a store waits for its ack
    set_prog(128'hE047_3CF0_0000_0000_0000_0000_5500_0000);
    start_prog(3, 0);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_req && mem_we) found = 1;
    end
    check("rst_sta stalled", 32'(found), 1);
    repeat (2) @(negedge clk);
    check("rst_sta addr_held", 32'(mem_addr), 12);
    check("rst_sta we_held", 32'(mem_we), 1);
    #1 rst_n = 1'b0;
    #1 check("rst_sta req_drop", 32'(mem_req), 0);
    @(negedge clk);
    clear_logs();
    check("rst_sta mem_kept", 32'(mem[12]), 32'h55);
    check("rst_sta pc", 32'(pc), 0);
    delay_mode = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    finish_prog("rst_sta", 1);
    check("rst_sta first_fetch", (req_log.size() > 0) ? req_log[0] : -1, 0);
    check("rst_sta a_cleared", (outs.size() > 0) ? outs[0] : -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
